// File: rtl/alu_result_stage_if.sv
// ---------------------------------------------------------------------------
// alu_result_stage_if
//   Bundles the two valid/ready streams around the ALU result stage.
//   Upstream stream  (ALU -> stage):      in_valid, in_ready, in_result, in_op
//   Downstream stream (stage -> consumer): out_valid, out_ready, out_result,
//                                          out_op, out_zero, out_neg, out_parity
//   Modports
//     master : the surrounding system (drives ALU results, consumes output)
//     slave  : the result stage itself
// ---------------------------------------------------------------------------
interface alu_result_stage_if #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic [OPW-1:0]   in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [OPW-1:0]   out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_parity;

  modport master (
    output in_valid, in_result, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
  );

  modport slave (
    input  in_valid, in_result, in_op, out_ready,
    output in_ready, out_valid, out_result, out_op, out_zero, out_neg, out_parity
  );
endinterface

// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//   Registered output stage behind the 64-bit ALU. Each accepted result is
//   stored together with its op tag and with zero/negative/parity flags that
//   are computed once, at capture. A two-entry skid buffer means in_ready is
//   a pure function of the occupancy register, so the ALU never sees a
//   combinational path from out_ready. A wrapping counter tracks delivered
//   results.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset, clears both entries
//   bus        : alu_result_stage_if.slave (both valid/ready streams)
//   res_count  : number of output handshakes, modulo 2^CNTW
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int WIDTH = 64,
  parameter int OPW   = 3,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_result_stage_if.slave     bus,
  output logic [CNTW-1:0]       res_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [OPW-1:0]   op;
    logic             zero;
    logic             neg;
    logic             parity;
  } entry_t;

  state_t state_reg;
  state_t state_next;

  // Slot 0 is always the head; slot 1 only holds data in state TWO.
  entry_t     slot      [2];
  entry_t     slot_next [2];
  logic [1:0] slot_load;

  entry_t in_entry;
  logic   push;
  logic   pop;

  logic [CNTW-1:0] cnt_reg;

  // Ready/valid come straight from the occupancy register.
  assign bus.in_ready  = (state_reg != TWO);
  assign bus.out_valid = (state_reg != EMPTY);

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // Flags are frozen at capture so the consumer sees them alongside the data
  // without any logic on the output side.
  always_comb begin
    in_entry.result = bus.in_result;
    in_entry.op     = bus.in_op;
    in_entry.zero   = (bus.in_result == '0);
    in_entry.neg    = bus.in_result[WIDTH-1];
    in_entry.parity = ^bus.in_result;
  end

  // Occupancy FSM and slot steering.
  always_comb begin
    state_next   = state_reg;
    slot_load    = 2'b00;
    slot_next[0] = slot[0];
    slot_next[1] = slot[1];

    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next   = ONE;
          slot_load[0] = 1'b1;
          slot_next[0] = in_entry;
        end
      end
      ONE: begin
        if (push && pop) begin
          // Head leaves and the new result takes its place directly.
          slot_load[0] = 1'b1;
          slot_next[0] = in_entry;
        end else if (push) begin
          state_next   = TWO;
          slot_load[1] = 1'b1;
          slot_next[1] = in_entry;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_next   = ONE;
          slot_load[0] = 1'b1;
          slot_next[0] = slot[1];
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_slot
      entry_t entry_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_reg <= '0;
        end else if (slot_load[gi]) begin
          entry_reg <= slot_next[gi];
        end
      end

      assign slot[gi] = entry_reg;
    end
  endgenerate

  // Free-running delivered-result counter; wraps silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (pop) begin
      cnt_reg <= cnt_reg + CNTW'(1);
    end
  end

  assign bus.out_result = slot[0].result;
  assign bus.out_op     = slot[0].op;
  assign bus.out_zero   = slot[0].zero;
  assign bus.out_neg    = slot[0].neg;
  assign bus.out_parity = slot[0].parity;
  assign res_count      = cnt_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_result_stage
//   Self-checking bench for alu_result_stage. A queue-based reference model
//   (capacity 2, FIFO order, flags derived from the stored value) predicts
//   ready/valid, head data and the delivered-result count every cycle.
// ---------------------------------------------------------------------------
module tb_alu_result_stage;
  localparam int WIDTH = 64;
  localparam int OPW   = 3;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [CNTW-1:0] res_count;

  alu_result_stage_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_result_stage #(.WIDTH(WIDTH), .OPW(OPW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [OPW-1:0]   op;
  } item_t;

  item_t           model [$];
  logic [CNTW-1:0] exp_count;
  int              checks = 0;
  int              errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare the DUT against the model just
  // before the edge, then advance the model by the handshakes that occur.
  task automatic step(input logic v, input logic [63:0] r, input logic [2:0] op,
                      input logic ordy, output logic pushed, output logic popped);
    item_t it;
    bus.in_valid  = v;
    bus.in_result = r;
    bus.in_op     = op;
    bus.out_ready = ordy;
    @(negedge clk);
    check_val("in_ready", bus.in_ready, 64'(model.size() < 2));
    check_val("out_valid", bus.out_valid, 64'(model.size() != 0));
    if (model.size() != 0) begin
      it = model[0];
      check_val("out_result", bus.out_result, it.r);
      check_val("out_op", 64'(bus.out_op), 64'(it.op));
      check_val("out_zero", 64'(bus.out_zero), 64'(it.r == 64'd0));
      check_val("out_neg", 64'(bus.out_neg), 64'(it.r[63]));
      check_val("out_parity", 64'(bus.out_parity), 64'(^it.r));
    end
    pushed = v && (model.size() < 2);
    popped = ordy && (model.size() != 0);
    if (popped) begin
      void'(model.pop_front());
      exp_count = exp_count + 16'd1;
    end
    if (pushed) model.push_back(item_t'{r: r, op: op});
    @(posedge clk);
    #1;
    check_val("res_count", 64'(res_count), 64'(exp_count));
  endtask

  task automatic drain();
    logic pu, po;
    for (int i = 0; i < 10 && model.size() != 0; i++) step(1'b0, 64'd0, 3'd0, 1'b1, pu, po);
    check_val("drain_empty", 64'(model.size()), 64'd0);
  endtask

  initial begin
    logic pu, po;
    int   pushes, cyc, chk0, err0;
    logic [63:0] a, b;

    bus.in_valid = 1'b0; bus.in_result = '0; bus.in_op = '0; bus.out_ready = 1'b0;
    exp_count = '0;
    repeat (3) @(posedge clk);
    // Reset state while rst_n is held low.
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_res_count", 64'(res_count), 64'd0);
    check_val("rst_out_result", bus.out_result, 64'd0);
    check_val("rst_flags", 64'({bus.out_op, bus.out_zero, bus.out_neg, bus.out_parity}), 64'd0);
    #1 rst_n = 1'b1;

    // T3 backpressure: A and B absorbed, C held until out_ready rises.
    step(1'b1, 64'hA, 3'd1, 1'b0, pu, po);
    check_val("t3_push_a", 64'(pu), 64'd1);
    step(1'b1, 64'hB, 3'd2, 1'b0, pu, po);
    check_val("t3_push_b", 64'(pu), 64'd1);
    check_val("t3_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'hC, 3'd3, 1'b0, pu, po);
      check_val("t3_c_held", 64'(pu), 64'd0);
    end
    pu = 1'b0;
    for (int i = 0; i < 10 && !pu; i++) step(1'b1, 64'hC, 3'd3, 1'b1, pu, po);
    check_val("t3_c_accepted", 64'(pu), 64'd1);
    drain();
    check_val("t3_count", 64'(res_count), 64'd3);

    // T1 reset with two entries held: effect is immediate, no edge needed.
    step(1'b1, 64'h11, 3'd5, 1'b0, pu, po);
    step(1'b1, 64'h22, 3'd6, 1'b0, pu, po);
    check_val("t1_full", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("t1_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("t1_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("t1_res_count", 64'(res_count), 64'd0);
    check_val("t1_out_result", bus.out_result, 64'd0);
    model.delete();
    exp_count = '0;
    bus.in_valid = 1'b1; bus.in_result = 64'h99; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check_val("t1_ignored_in", 64'(bus.out_valid), 64'd0);

    // T2 flow-through: 0xFF & b for b = 1..256, one per cycle.
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 64'hFF & 64'(i), 3'd0, 1'b1, pu, po);
      check_val("t2_accept", 64'(pu), 64'd1);
    end
    drain();
    check_val("t2_count", 64'(res_count), 64'd256);

    // T4 simultaneous push/pop while holding one entry.
    step(1'b1, 64'h1234, 3'd2, 1'b0, pu, po);
    step(1'b1, 64'h8000_0000_0000_0001, 3'd4, 1'b1, pu, po);
    check_val("t4_push", 64'(pu), 64'd1);
    check_val("t4_pop", 64'(po), 64'd1);
    check_val("t4_valid", 64'(bus.out_valid), 64'd1);
    check_val("t4_ready", 64'(bus.in_ready), 64'd1);
    check_val("t4_result", bus.out_result, 64'h8000_0000_0000_0001);
    check_val("t4_neg", 64'(bus.out_neg), 64'd1);
    check_val("t4_parity", 64'(bus.out_parity), 64'd0);
    check_val("t4_zero", 64'(bus.out_zero), 64'd0);
    drain();

    // T6 random traffic against the model.
    chk0 = checks; err0 = errors; pushes = 0; cyc = 0;
    while (pushes < 10000 && cyc < 60000) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), a & b, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), pu, po);
      if (pu) pushes++;
      cyc++;
    end
    check_val("t6_pushes", 64'(pushes), 64'd10000);
    drain();
    $display("T6 random: correct=%0d wrong=%0d", (checks - chk0) - (errors - err0), errors - err0);

    // T5 counter wrap: keep streaming until the count reaches 0xFFFF.
    cyc = 0;
    while (exp_count != 16'hFFFF && cyc < 70000) begin
      step(1'b1, 64'(cyc), 3'd1, 1'b1, pu, po);
      cyc++;
    end
    check_val("t5_ffff", 64'(res_count), 64'hFFFF);
    po = 1'b0;
    for (int i = 0; i < 4 && !po; i++) step(1'b1, 64'h5, 3'd1, 1'b1, pu, po);
    check_val("t5_wrap0", 64'(res_count), 64'h0000);
    po = 1'b0;
    for (int i = 0; i < 4 && !po; i++) step(1'b0, 64'h0, 3'd0, 1'b1, pu, po);
    check_val("t5_wrap1", 64'(res_count), 64'h0001);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
